tlb_op_controller: RTL
======================

// Module: tlb_op_controller
// PURPOSE
//  CP0-side sequencer for the TLB instructions TLBP, TLBR, TLBWI and TLBWR; it is the initiator of the tlb search/read/write ports.
//  Accepts one op per handshake, samples the EntryHi/EntryLo0/EntryLo1/Index operands, drives the tlb, and returns CP0 update values with a done pulse.
//  Sits between the CP0 register file and the tlb.
// PARAMETERS
//  TLB_NUM  16  TLB entry count; IW = $clog2(TLB_NUM)
// PORTS
//  clock          in   1    single clock; all state on posedge
//  reset          in   1    synchronous, active-high
//  op_valid       in   1    op request
//  op_ready       out  1    high only in IDLE
//  op_type        in   2    0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
//  in_index       in   IW   Index register
//  in_vpn2        in   19   EntryHi.VPN2
//  in_asid        in   8    EntryHi.ASID
//  in_lo0/in_lo1  in   26   EntryLo {pfn[25:6],c[5:3],d[2],v[1],g[0]}
//  in_wired       in   IW   Wired register
//  wired_we       in   1    Wired is being written this cycle
//  done           out  1    one-cycle completion pulse
//  probe_miss     out  1    TLBP result (Index.P)
//  out_index      out  IW   TLBP hit index
//  out_vpn2/out_asid out 19/8  TLBR EntryHi values
//  out_lo0/out_lo1   out 26    TLBR EntryLo values
//  random         out  IW   Random register
//  s_vpn2/s_asid  out  19/8 search request; s_odd_page tied 0
//  s_found/s_index in  1/IW search result (combinational from tlb)
//  we/w_index     out  1/IW write strobe and index
//  w_entry        out  78   tlb_params::tlb_request_t
//  r_index        out  IW   read index
//  r_entry        in   78   tlb_params::tlb_request_t
// BEHAVIOUR
//  - Reset values: done, probe_miss, we = 0; all out_* = 0; state = IDLE; random = TLB_NUM-1.
//  - FSM IDLE->ISSUE->RESP->IDLE. Accept when op_valid&&op_ready.
//  - At accept, all in_* operands and op_type are registered; later in_* changes are ignored.
//  - ISSUE: drive s_*, r_index and w_* from the registered operands.
//    - TLBWI: we=1, w_index = idx.
//    - TLBWR: we=1, w_index = random sampled at accept.
//    - we is high only in ISSUE.
//  - End of ISSUE: capture s_found/s_index (TLBP) or r_entry (TLBR).
//  - RESP: done=1 for one cycle. Latency is accept -> done = 2 cycles. Next accept is possible the cycle after RESP.
//  - TLBP:
//    - Hit: probe_miss=0, out_index=s_index.
//    - Miss: probe_miss=1, out_index holds its prior value.
//  - TLBR: out_* are unpacked from r_entry; lo0.g = lo1.g = r_entry.is_global.
//  - Write: w_entry.is_global = lo0.g & lo1.g; pfn/c/d/v are taken from the matching lo.
//  - out_* and probe_miss hold until the next op of the same type updates them.
//  - op_valid while not IDLE is ignored (op_ready=0); no queueing.
//  - Random (decrement priority, highest first):
//    1. reset or wired_we -> TLB_NUM-1.
//    2. random==in_wired -> TLB_NUM-1.
//    3. otherwise random-1, every cycle.
//  - Random boundary: if in_wired >= TLB_NUM-1, random stays at TLB_NUM-1.
//  - Reset mid-op: FSM returns to IDLE immediately; no we and no done for the aborted op.
// CONFIGURATION
//  - TLB_RANDOM_EN defined: Random counter, random port and TLBWR are as above.
//  - Undefined: no counter; random = 0 constant; op_type 3 behaves exactly as TLBWI (uses in_index); in_wired and wired_we are unused.
// STRUCTURE
//  - tlb_params package: tlb_request_t, search_request_t, search_result_t (shared), plus new tlb_op_e enum and entry_lo_t packed struct (26b).
//  - Sub-module tlb_random_counter: Random counter only, instantiated under TLB_RANDOM_EN; the FSM stays in this module.
// TESTING
//  - Reset, then idle: op_ready=1, done=0, we=0, random = 15,14,... down to in_wired=2, then wraps to 15.
//  - TLBWI idx=5, vpn2=0x1234, asid=0x22, lo0.g=1, lo1.g=0 -> we for 1 cycle with w_index=5, is_global=0; done 2 cycles after accept.
//  - TLBP after that write with vpn2=0x1234, asid=0x22 -> probe_miss=0, out_index=5.
//    - Same probe with asid=0x33 -> probe_miss=1, out_index stays 5.
//  - TLBR idx=5 -> out_vpn2=0x1234, out_asid=0x22, out_lo0[0]=out_lo1[0]=0; op_valid held during busy cycles is not re-accepted.
//  - TLBWR with random=9 at accept -> w_index=9; wired_we mid-op leaves w_index=9 and resets random to 15.
//  - Reset asserted in ISSUE of TLBWI -> we low from next edge, no done, op_ready=1.

Source files
------------

// File: rtl/tlb_op_controller_pkg.sv
// Shared TLB types (package tlb_params): tlb port payloads, op encoding,
// EntryLo layout and the sequencer state encoding.
package tlb_params;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        is_global;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_request_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic        odd_page;
        logic [7:0]  asid;
    } search_request_t;

    typedef struct packed {
        logic       found;
        logic [7:0] index;
    } search_result_t;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } entry_lo_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } ctrl_state_e;

endpackage

// File: rtl/tlb_op_controller_if.sv
// CP0 op handshake plus tlb search/read/write ports of the TLB op sequencer.
// master = sequencer side, slave = CP0 register file and tlb side.
interface tlb_op_controller_if import tlb_params::*; #(parameter int unsigned TLB_NUM = 16);

    localparam int unsigned IW = $clog2(TLB_NUM);

    logic            op_valid;
    logic            op_ready;
    logic [1:0]      op_type;
    logic [IW-1:0]   in_index;
    logic [18:0]     in_vpn2;
    logic [7:0]      in_asid;
    entry_lo_t       in_lo0;
    entry_lo_t       in_lo1;
    logic [IW-1:0]   in_wired;
    logic            wired_we;
    logic            done;
    logic            probe_miss;
    logic [IW-1:0]   out_index;
    logic [18:0]     out_vpn2;
    logic [7:0]      out_asid;
    entry_lo_t       out_lo0;
    entry_lo_t       out_lo1;
    logic [IW-1:0]   random;
    logic [18:0]     s_vpn2;
    logic [7:0]      s_asid;
    logic            s_odd_page;
    logic            s_found;
    logic [IW-1:0]   s_index;
    logic            we;
    logic [IW-1:0]   w_index;
    tlb_request_t    w_entry;
    logic [IW-1:0]   r_index;
    tlb_request_t    r_entry;

    modport master (
        input  op_valid, op_type, in_index, in_vpn2, in_asid, in_lo0, in_lo1,
               in_wired, wired_we, s_found, s_index, r_entry,
        output op_ready, done, probe_miss, out_index, out_vpn2, out_asid,
               out_lo0, out_lo1, random, s_vpn2, s_asid, s_odd_page,
               we, w_index, w_entry, r_index
    );

    modport slave (
        output op_valid, op_type, in_index, in_vpn2, in_asid, in_lo0, in_lo1,
               in_wired, wired_we, s_found, s_index, r_entry,
        input  op_ready, done, probe_miss, out_index, out_vpn2, out_asid,
               out_lo0, out_lo1, random, s_vpn2, s_asid, s_odd_page,
               we, w_index, w_entry, r_index
    );

endinterface

// File: rtl/tlb_op_controller_random_counter.sv
// CP0 Random register: counts down every cycle, reloads to TLB_NUM-1 on reset,
// Wired write, or reaching Wired. Only instantiated when TLB_RANDOM_EN is defined.
module tlb_random_counter #(
    parameter int unsigned TLB_NUM = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wired_we,
    input  logic [$clog2(TLB_NUM)-1:0] wired,
    output logic [$clog2(TLB_NUM)-1:0] random
);

    localparam int unsigned IW = $clog2(TLB_NUM);
    localparam logic [IW-1:0] TOP = IW'(TLB_NUM - 1);
    localparam logic [IW-1:0] ONE = IW'(1);

    // wired >= TOP pins the counter at TOP so it never runs below Wired
    always_ff @(posedge clock) begin
        if (reset || wired_we) begin
            random <= TOP;
        end else if (random == wired || wired >= TOP) begin
            random <= TOP;
        end else begin
            random <= random - ONE;
        end
    end

endmodule

// File: rtl/tlb_op_controller.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: IDLE -> ISSUE -> RESP with a done pulse.
// Define TLB_RANDOM_EN to enable the Random counter and random-indexed TLBWR.
module tlb_op_controller import tlb_params::*; #(
    parameter int unsigned TLB_NUM = 16
) (
    input logic                  clock,
    input logic                  reset,
    tlb_op_controller_if.master  bus
);

    localparam int unsigned IW = $clog2(TLB_NUM);

    ctrl_state_e   state;
    tlb_op_e       op_q;
    tlb_op_e       op_in;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] widx_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;
    entry_lo_t     lo0_q;
    entry_lo_t     lo1_q;
    logic          we_q;
    logic          done_q;
    logic          miss_q;
    logic [IW-1:0] oidx_q;
    logic [18:0]   ovpn2_q;
    logic [7:0]    oasid_q;
    entry_lo_t     olo0_q;
    entry_lo_t     olo1_q;
    logic [IW-1:0] random_q;
    logic [IW-1:0] wr_index;

    assign op_in = tlb_op_e'(bus.op_type);

`ifdef TLB_RANDOM_EN
    tlb_random_counter #(.TLB_NUM(TLB_NUM)) u_random (
        .clock    (clock),
        .reset    (reset),
        .wired_we (bus.wired_we),
        .wired    (bus.in_wired),
        .random   (random_q)
    );
    assign wr_index = (op_in == OP_TLBWR) ? random_q : bus.in_index;
`else
    logic unused_wired;
    assign unused_wired = ^{bus.in_wired, bus.wired_we};
    assign random_q     = '0;
    assign wr_index     = bus.in_index;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_TLBP;
            idx_q   <= '0;
            widx_q  <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
            oidx_q  <= '0;
            ovpn2_q <= '0;
            oasid_q <= '0;
            olo0_q  <= '0;
            olo1_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        op_q   <= op_in;
                        idx_q  <= bus.in_index;
                        widx_q <= wr_index;
                        vpn2_q <= bus.in_vpn2;
                        asid_q <= bus.in_asid;
                        lo0_q  <= bus.in_lo0;
                        lo1_q  <= bus.in_lo1;
                        we_q   <= (op_in == OP_TLBWI) || (op_in == OP_TLBWR);
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_RESP;
                    // a probe miss keeps the previous Index value
                    if (op_q == OP_TLBP) begin
                        miss_q <= !bus.s_found;
                        if (bus.s_found) oidx_q <= bus.s_index;
                    end else if (op_q == OP_TLBR) begin
                        ovpn2_q <= bus.r_entry.vpn2;
                        oasid_q <= bus.r_entry.asid;
                        olo0_q  <= '{pfn: bus.r_entry.pfn0, c: bus.r_entry.c0, d: bus.r_entry.d0,
                                     v: bus.r_entry.v0, g: bus.r_entry.is_global};
                        olo1_q  <= '{pfn: bus.r_entry.pfn1, c: bus.r_entry.c1, d: bus.r_entry.d1,
                                     v: bus.r_entry.v1, g: bus.r_entry.is_global};
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready   = (state == ST_IDLE);
    assign bus.done       = done_q;
    assign bus.probe_miss = miss_q;
    assign bus.out_index  = oidx_q;
    assign bus.out_vpn2   = ovpn2_q;
    assign bus.out_asid   = oasid_q;
    assign bus.out_lo0    = olo0_q;
    assign bus.out_lo1    = olo1_q;
    assign bus.random     = random_q;
    assign bus.s_vpn2     = vpn2_q;
    assign bus.s_asid     = asid_q;
    assign bus.s_odd_page = 1'b0;
    assign bus.r_index    = idx_q;
    assign bus.we         = we_q;
    assign bus.w_index    = widx_q;
    assign bus.w_entry    = '{vpn2: vpn2_q, asid: asid_q, is_global: lo0_q.g & lo1_q.g,
                              pfn0: lo0_q.pfn, c0: lo0_q.c, d0: lo0_q.d, v0: lo0_q.v,
                              pfn1: lo1_q.pfn, c1: lo1_q.c, d1: lo1_q.d, v1: lo1_q.v};

endmodule
